// File: rtl/compute_unit_pipe.sv
// Register-file compute unit: one instruction per cycle over valid/ready,
// single-cycle ALU ops, iterative shift-add multiply, one-entry output buffer.
module compute_unit_pipe #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 16,
    localparam int RIDW  = $clog2(NREGS),
    localparam int IW    = 4 + 3 * RIDW
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IW-1:0]     instruction,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [RIDW-1:0]   out_reg_id,
    output logic              out_zero,
    output logic              out_carry,
    output logic              out_err
);

    localparam int SHW  = $clog2(DATA_W);
    localparam int IMMW = 2 * RIDW;
    localparam int CPW  = (IMMW < DATA_W) ? IMMW : DATA_W;
    localparam int CNTW = $clog2(DATA_W + 1);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LOAD = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_NOT  = 4'h6,
        OP_XOR  = 4'h7,
        OP_SHL  = 4'h8,
        OP_SHR  = 4'h9,
        OP_MUL  = 4'hA
    } op_e;

    typedef enum logic {
        RUN,
        MUL_BUSY
    } state_e;

    state_e state;
    state_e state_next;

    logic [DATA_W-1:0] regs [NREGS];

    op_e               op;
    logic [RIDW-1:0]   tgt;
    logic [RIDW-1:0]   src0;
    logic [RIDW-1:0]   src1;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;

    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic              alu_err;
    logic [DATA_W:0]   sum;

    logic [DATA_W-1:0] mul_acc;
    logic [DATA_W-1:0] mul_mcand;
    logic [DATA_W-1:0] mul_mplier;
    logic [RIDW-1:0]   mul_tgt;
    logic [CNTW-1:0]   mul_cnt;
    logic [DATA_W-1:0] mul_sum;

    logic              accept;
    logic              load_buf;
    logic              wr_en;
    logic [RIDW-1:0]   wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic              res_carry;
    logic              res_err;
    logic              mul_start;

    assign op   = op_e'(instruction[IW-1 -: 4]);
    assign tgt  = instruction[3*RIDW-1 -: RIDW];
    assign src0 = instruction[2*RIDW-1 -: RIDW];
    assign src1 = instruction[RIDW-1:0];
    assign a    = regs[src0];
    assign b    = regs[src1];
    assign imm  = DATA_W'(instruction[CPW-1:0]);

    assign in_ready = rstn && (state == RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Final partial product is folded in combinationally so the last step can write back directly.
    assign mul_sum = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_err   = 1'b0;
        sum       = {1'b0, a} + {1'b0, b};
        case (op)
            OP_LOAD: alu_res = imm;
            OP_ADD: begin
                alu_res   = sum[DATA_W-1:0];
                alu_carry = sum[DATA_W];
            end
            OP_SUB: begin
                alu_res   = a - b;
                alu_carry = (a < b);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_NOT:  alu_res = ~a;
            OP_XOR:  alu_res = a ^ b;
            OP_SHL:  alu_res = a << b[SHW-1:0];
            OP_SHR:  alu_res = a >> b[SHW-1:0];
            OP_NOP, OP_MUL: alu_res = '0;
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        load_buf   = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = tgt;
        wr_data    = alu_res;
        res_carry  = alu_carry;
        res_err    = alu_err;
        mul_start  = 1'b0;
        case (state)
            RUN: begin
                if (accept && op != OP_NOP) begin
                    if (op == OP_MUL) begin
                        state_next = MUL_BUSY;
                        mul_start  = 1'b1;
                    end else begin
                        load_buf = 1'b1;
                        wr_en    = !alu_err;
                    end
                end
            end
            MUL_BUSY: begin
                if (mul_cnt == CNTW'(1)) begin
                    state_next = RUN;
                    load_buf   = 1'b1;
                    wr_en      = 1'b1;
                    wr_idx     = mul_tgt;
                    wr_data    = mul_sum;
                    res_carry  = 1'b0;
                    res_err    = 1'b0;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_idx] <= wr_data;
        end
    end

    // Multiplicand shifts left and multiplier shifts right, one bit per cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_tgt    <= '0;
            mul_cnt    <= '0;
        end else if (mul_start) begin
            mul_acc    <= '0;
            mul_mcand  <= a;
            mul_mplier <= b;
            mul_tgt    <= tgt;
            mul_cnt    <= CNTW'(DATA_W);
        end else if (state == MUL_BUSY) begin
            mul_acc    <= mul_sum;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_cnt    <= mul_cnt - CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_reg_id <= '0;
            out_zero   <= 1'b0;
            out_carry  <= 1'b0;
            out_err    <= 1'b0;
        end else if (load_buf) begin
            out_valid  <= 1'b1;
            out_data   <= wr_data;
            out_reg_id <= wr_idx;
            out_zero   <= (wr_data == '0);
            out_carry  <= res_carry;
            out_err    <= res_err;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_compute_unit_pipe.sv
// Scoreboard bench for compute_unit_pipe: an 8-bit/16-register and a
// 16-bit/32-register instance checked against a plain arithmetic reference.
module tb_compute_unit_pipe;

    localparam int OP_LOAD = 1;
    localparam int OP_ADD  = 2;
    localparam int OP_SUB  = 3;
    localparam int OP_OR   = 5;
    localparam int OP_NOT  = 6;
    localparam int OP_SHL  = 8;
    localparam int OP_SHR  = 9;
    localparam int OP_MUL  = 10;

    typedef struct {
        logic [31:0] data;
        logic [31:0] rid;
        logic        zero;
        logic        carry;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid_a, in_valid_b;
    logic        in_ready_a, in_ready_b;
    logic [15:0] instr_a;
    logic [18:0] instr_b;
    logic        out_valid_a, out_valid_b;
    logic        out_ready_a, out_ready_b;
    logic [7:0]  data_a;
    logic [15:0] data_b;
    logic [3:0]  rid_a;
    logic [4:0]  rid_b;
    logic        zero_a, zero_b, carry_a, carry_b, err_a, err_b;

    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    int unsigned rf[2][32];
    bit          rand_ready = 1'b0;
    logic        forced_ready = 1'b1;

    compute_unit_pipe #(.DATA_W(8), .NREGS(16)) dut_a (
        .clk(clk), .rstn(rstn), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .instruction(instr_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_data(data_a), .out_reg_id(rid_a), .out_zero(zero_a),
        .out_carry(carry_a), .out_err(err_a)
    );

    compute_unit_pipe #(.DATA_W(16), .NREGS(32)) dut_b (
        .clk(clk), .rstn(rstn), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .instruction(instr_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_data(data_b), .out_reg_id(rid_b), .out_zero(zero_b),
        .out_carry(carry_b), .out_err(err_b)
    );

    always #5 clk = ~clk;

    function automatic int dwOf(input int k);
        return (k == 0) ? 8 : 16;
    endfunction

    function automatic int rwOf(input int k);
        return (k == 0) ? 4 : 5;
    endfunction

    function automatic logic rdy(input int k);
        return (k == 0) ? in_ready_a : in_ready_b;
    endfunction

    function automatic logic ovld(input int k);
        return (k == 0) ? out_valid_a : out_valid_b;
    endfunction

    function automatic logic ordy(input int k);
        return (k == 0) ? out_ready_a : out_ready_b;
    endfunction

    function automatic exp_t sampleOut(input int k);
        exp_t s;
        s.data  = (k == 0) ? 32'(data_a) : 32'(data_b);
        s.rid   = (k == 0) ? 32'(rid_a) : 32'(rid_b);
        s.zero  = (k == 0) ? zero_a : zero_b;
        s.carry = (k == 0) ? carry_a : carry_b;
        s.err   = (k == 0) ? err_a : err_b;
        return s;
    endfunction

    function automatic logic [18:0] mk(input int k, input int op, input int t, input int s0, input int s1);
        int r = rwOf(k);
        return 19'((op << (3 * r)) | (t << (2 * r)) | (s0 << r) | s1);
    endfunction

    function automatic logic [18:0] mkImm(input int k, input int t, input int imm);
        int r = rwOf(k);
        return 19'((OP_LOAD << (3 * r)) | (t << (2 * r)) | (imm & ((1 << (2 * r)) - 1)));
    endfunction

    // Reference model: decode fields arithmetically and apply the opcode rules.
    function automatic void modelAccept(input int k, input logic [18:0] ins);
        int          r = rwOf(k);
        int          dw = dwOf(k);
        int unsigned mask = (32'd1 << dw) - 1;
        int unsigned iv = 32'(ins);
        int          op = int'((iv >> (3 * r)) & 15);
        int          t = int'((iv >> (2 * r)) & ((1 << r) - 1));
        int          s0 = int'((iv >> r) & ((1 << r) - 1));
        int          s1 = int'(iv & ((1 << r) - 1));
        int unsigned a = rf[k][s0];
        int unsigned b = rf[k][s1];
        int unsigned res = 0;
        bit          c = 1'b0;
        bit          e = 1'b0;
        exp_t        x;
        case (op)
            0:  return;
            1:  res = iv & ((32'd1 << (2 * r)) - 1) & mask;
            2: begin
                res = (a + b) & mask;
                c = (((a + b) >> dw) & 1) != 0;
            end
            3: begin
                res = (a - b) & mask;
                c = (a < b);
            end
            4:  res = a & b;
            5:  res = a | b;
            6:  res = (~a) & mask;
            7:  res = a ^ b;
            8:  res = (a << (b % dw)) & mask;
            9:  res = a >> (b % dw);
            10: res = (a * b) & mask;
            default: e = 1'b1;
        endcase
        if (!e) rf[k][t] = res;
        x.data = res; x.rid = t; x.zero = (res == 0); x.carry = c; x.err = e;
        if (k == 0) q0.push_back(x); else q1.push_back(x);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic drive(input int k, input logic v, input logic [18:0] ins);
        if (k == 0) begin
            in_valid_a = v;
            instr_a = ins[15:0];
        end else begin
            in_valid_b = v;
            instr_b = ins;
        end
    endtask

    task automatic applyStimulus(input int k, input logic [18:0] ins);
        int waited = 0;
        @(negedge clk);
        drive(k, 1'b1, ins);
        #2;
        while (!rdy(k) && waited < 300) begin
            @(negedge clk);
            #2;
            waited++;
        end
        if (!rdy(k)) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL accept_timeout: in_ready got 0, required 1");
        end else begin
            @(posedge clk);
            modelAccept(k, ins);
        end
        #1 drive(k, 1'b0, ins);
    endtask

    task automatic monitor(input int k);
        exp_t cur, held, e;
        bit   stalled = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (!rstn) begin
                stalled = 1'b0;
                continue;
            end
            cur = sampleOut(k);
            if (stalled) begin
                checkOutput("hold_valid", 32'(ovld(k)), 32'd1);
                checkOutput("hold_data", cur.data, held.data);
                checkOutput("hold_reg_id", cur.rid, held.rid);
            end
            if (ovld(k) && ordy(k)) begin
                stalled = 1'b0;
                if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_output: inst %0d data 0x%0h reg %0d, required no output", k, cur.data, cur.rid);
                end else begin
                    e = (k == 0) ? q0.pop_front() : q1.pop_front();
                    checkOutput("out_data", cur.data, e.data);
                    checkOutput("out_reg_id", cur.rid, e.rid);
                    checkOutput("out_zero", 32'(cur.zero), 32'(e.zero));
                    checkOutput("out_carry", 32'(cur.carry), 32'(e.carry));
                    checkOutput("out_err", 32'(cur.err), 32'(e.err));
                end
            end else if (ovld(k)) begin
                stalled = 1'b1;
                held = cur;
            end else begin
                stalled = 1'b0;
            end
        end
    endtask

    task automatic mulLatency(input int k, input logic [18:0] ins);
        int cyc = 0;
        bit busy_ok = 1'b1;
        applyStimulus(k, ins);
        while (cyc < 40) begin
            @(negedge clk);
            #3;
            if (ovld(k)) break;
            if (rdy(k)) busy_ok = 1'b0;
            cyc++;
        end
        checkOutput("mul_latency", 32'(cyc), 32'(dwOf(k)));
        checkOutput("mul_in_ready_low", 32'(busy_ok), 32'd1);
    endtask

    task automatic drainCheck(input int k);
        rand_ready = 1'b0;
        forced_ready = 1'b1;
        repeat (25) @(negedge clk);
        checkOutput("drain_queue", 32'((k == 0) ? q0.size() : q1.size()), 32'd0);
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        out_ready_a = 1'b1;
        out_ready_b = 1'b1;
        forever begin
            @(negedge clk);
            out_ready_a = rand_ready ? ($urandom_range(0, 3) != 0) : forced_ready;
            out_ready_b = rand_ready ? ($urandom_range(0, 3) != 0) : forced_ready;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   busy_seen;
        bit   no_out;
        exp_t s;
        rstn = 1'b0;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        repeat (3) @(negedge clk);
        #3;
        s = sampleOut(0);
        checkOutput("rst_in_ready_a", 32'(in_ready_a), 32'd0);
        checkOutput("rst_in_ready_b", 32'(in_ready_b), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid_a), 32'd0);
        checkOutput("rst_out_data", s.data, 32'd0);
        checkOutput("rst_out_reg_id", s.rid, 32'd0);
        checkOutput("rst_out_flags", {29'd0, s.zero, s.carry, s.err}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #3 checkOutput("ready_after_reset", 32'(in_ready_a), 32'd1);

        applyStimulus(0, mkImm(0, 1, 8'h05));
        applyStimulus(0, mkImm(0, 2, 8'h03));
        applyStimulus(0, mk(0, OP_ADD, 3, 1, 2));
        applyStimulus(0, mkImm(0, 1, 8'hFF));
        applyStimulus(0, mkImm(0, 2, 8'h01));
        applyStimulus(0, mk(0, OP_ADD, 4, 1, 2));
        applyStimulus(0, mk(0, OP_SUB, 5, 2, 1));
        applyStimulus(0, mkImm(0, 1, 8'h0C));
        applyStimulus(0, mkImm(0, 2, 8'h0B));
        applyStimulus(0, mkImm(0, 0, 8'h00));
        repeat (3) @(negedge clk);
        mulLatency(0, mk(0, OP_MUL, 6, 1, 2));

        // Back-pressure: pending output stalls the streaming instruction for 5 cycles.
        repeat (3) @(negedge clk);
        #1 forced_ready = 1'b0;
        applyStimulus(0, mkImm(0, 8, 8'h5A));
        fork
            applyStimulus(0, mk(0, OP_ADD, 9, 8, 8));
            begin
                repeat (5) begin
                    @(negedge clk);
                    #3 checkOutput("stall_in_ready", 32'(in_ready_a), 32'd0);
                end
                forced_ready = 1'b1;
            end
        join

        applyStimulus(0, mk(0, 12, 1, 2, 3));
        applyStimulus(0, mk(0, OP_OR, 11, 1, 0));
        applyStimulus(0, mk(0, OP_NOT, 7, 0, 0));
        applyStimulus(0, mkImm(0, 12, 8'h81));
        applyStimulus(0, mkImm(0, 13, 8'h01));
        applyStimulus(0, mk(0, OP_SHL, 14, 12, 13));
        applyStimulus(0, mk(0, OP_SHR, 15, 12, 13));

        rand_ready = 1'b1;
        repeat (300) applyStimulus(0, 19'($urandom) & 19'hFFFF);
        drainCheck(0);

        // Reset during the third cycle of a multiply abandons it.
        applyStimulus(0, mkImm(0, 1, 8'h0C));
        applyStimulus(0, mkImm(0, 2, 8'h0B));
        repeat (3) @(negedge clk);
        applyStimulus(0, mk(0, OP_MUL, 6, 1, 2));
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) for (int i = 0; i < 32; i++) rf[k][i] = 0;
        #3 checkOutput("rst_mid_mul_in_ready", 32'(in_ready_a), 32'd0);
        @(negedge clk);
        #3;
        s = sampleOut(0);
        checkOutput("rst_mid_mul_valid", 32'(out_valid_a), 32'd0);
        checkOutput("rst_mid_mul_data", s.data, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        no_out = 1'b1;
        busy_seen = 0;
        repeat (12) begin
            @(negedge clk);
            #3;
            if (out_valid_a) no_out = 1'b0;
            if (!in_ready_a) busy_seen++;
        end
        checkOutput("rst_mid_mul_no_output", 32'(no_out), 32'd1);
        checkOutput("rst_mid_mul_idle", 32'(busy_seen), 32'd0);
        for (int i = 0; i < 16; i++) applyStimulus(0, mk(0, OP_OR, i, i, i));
        drainCheck(0);

        applyStimulus(1, mkImm(1, 1, 16'h0081));
        applyStimulus(1, mkImm(1, 2, 16'h0001));
        applyStimulus(1, mk(1, OP_SHL, 3, 1, 2));
        applyStimulus(1, mk(1, OP_SHR, 4, 1, 2));
        applyStimulus(1, mkImm(1, 5, 16'h03FF));
        applyStimulus(1, mk(1, OP_ADD, 6, 5, 1));
        applyStimulus(1, mk(1, OP_NOT, 7, 0, 0));
        applyStimulus(1, mk(1, OP_ADD, 8, 7, 2));
        applyStimulus(1, mk(1, OP_SUB, 9, 2, 7));
        repeat (3) @(negedge clk);
        mulLatency(1, mk(1, OP_MUL, 10, 5, 5));
        rand_ready = 1'b1;
        repeat (150) applyStimulus(1, 19'($urandom));
        drainCheck(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
